prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer-side counterpart of the instruction decoder: accepts a stream of (OPECODE, imm) pairs over a valid/ready handshake.
- Encodes each pair into the 8-bit instruction word the decoder consumes and writes the words sequentially into the 16-word program memory from address 0.
- Sits between the host/debug port and program memory, and holds the CPU while loading.

Parameters:
ADDR_W, 4, program memory address width; depth = 2**ADDR_W words (16 by default)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse, begins a load session
in_valid  input  1  in_opecode/in_imm/in_last valid
in_ready  output  1  loader accepts a pair this cycle
in_opecode  input  OPECODE  operation to encode
in_imm  input  4  immediate field
in_last  input  1  current pair is the final instruction
mem_we  output  1  program memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  encoded instruction word
cpu_hold  output  1  keeps the CPU in reset while high
done  output  1  one-cycle pulse, load completed
error  output  1  sticky, INVALID opcode received

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high.
- Reset values: state IDLE; in_ready, mem_we, cpu_hold, done, error = 0; mem_addr = 0; mem_wdata = 0x00.
- Encoding, upper nibble:
  - MOV_A_B=0001, MOV_B_A=0100, MOV_A_IMM=0011, MOV_B_IMM=0111
  - IN_A=0010, IN_B=0110, OUT_B=1001, OUT_IMM=1011
  - ADD_A_IMM=0000, ADD_B_IMM=0101, JMP_IMM=1111, JNC_IMM=1110
- Encoding, lower nibble: in_imm for the *_IMM ops; forced to 0000 for MOV_A_B, MOV_B_A, IN_A, IN_B, OUT_B.
- States: IDLE, LOAD, FIN, ERR (PAD added with the optional feature).
- IDLE:
  - in_ready = 0, cpu_hold = 0.
  - start -> LOAD; write pointer = 0; cpu_hold = 1 from the next cycle; error cleared.
- LOAD:
  - in_ready = 1.
  - Transfer occurs when in_valid && in_ready.
  - Valid opcode: next cycle mem_we = 1, mem_addr = pointer, mem_wdata = encoded word (latency 1 cycle); pointer increments.
  - INVALID opcode: no write, error = 1, -> ERR.
  - Transfer with in_last = 1, or transfer at pointer = 2**ADDR_W-1 -> FIN, after that word is written. The write at the top address ends the session; no wrap-around, and further input is not accepted.
- FIN:
  - done = 1 for exactly one cycle, cpu_hold = 0 the following cycle, -> IDLE.
  - mem_we is low in FIN.
- ERR:
  - cpu_hold = 1, in_ready = 0, error held high.
  - Only start (-> LOAD, error cleared) or rst leaves ERR.
- start while in LOAD or FIN: ignored.
- in_valid while in_ready = 0: not consumed. The producer holds its data until a transfer.
- rst mid-load: immediate return to reset values. Words already written stay in memory. cpu_hold drops, so the CPU runs a partially loaded image; that is the producer's responsibility.
- mem_we never asserts outside the cycle after a transfer, or outside PAD.

Optional Feature:
- Macro: PROG_LOADER_PAD_EN.
- Defined:
  - A session ending with in_last below the top address goes LOAD -> PAD.
  - PAD writes one word per cycle at every remaining address a: {1111, a} (JMP to self), with in_ready = 0.
  - Then FIN. done pulses after the write at 2**ADDR_W-1.
- Undefined: no PAD state; remaining words keep their previous contents.

Decomposition:
- lib_cpu package: OPECODE enum (shared with the decoder); localparams for each opcode nibble, so encoder and decoder use one table; loader state enum.
- Sub-module inst_encoder:
  - Purely combinational: OPECODE + imm -> 8-bit word + invalid flag.
  - Also reused by the test assembler.

Test Plan:
- Basic load: start, then MOV_A_IMM/3, ADD_A_IMM/1, OUT_B/7 (last).
  - Writes 0x33 @0, 0x01 @1, 0x90 @2 (imm masked).
  - done pulses one cycle after the last write; cpu_hold high from start+1 until after done.
- Backpressure and gaps: in_valid toggles 1/0 randomly.
  - Exactly one write per accepted pair, addresses contiguous, no write in idle cycles.
- Full depth: 16 pairs JMP_IMM/i, none with in_last.
  - Writes 0xF0..0xFF @0..15; FIN after the 16th; the 17th in_valid is not accepted (in_ready = 0).
- Invalid opcode: ADD_B_IMM/2 then INVALID.
  - 0x52 @0, no second write, error = 1, cpu_hold stays 1.
  - A new start clears error and reloads from address 0.
- rst at pointer = 5 during LOAD:
  - Next cycle all outputs at reset values; no further writes.
  - A following start loads from address 0.
- With PROG_LOADER_PAD_EN: 2 pairs, last on the 2nd.
  - Words @2..15 = 0xF2..0xFF, done after the write @15.
  - Without the macro: done right after the write @1.

Source files
------------

// File: rtl/lib_cpu_pkg.sv
// lib_cpu: opcode enumeration and nibble table shared by the instruction
// encoder (loader side) and the decoder, plus the loader state type.
// Optional build macro: PROG_LOADER_PAD_EN (adds the PAD loader state).
package lib_cpu;

   typedef enum logic [3:0] {
      MOV_A_B,
      MOV_B_A,
      MOV_A_IMM,
      MOV_B_IMM,
      IN_A,
      IN_B,
      OUT_B,
      OUT_IMM,
      ADD_A_IMM,
      ADD_B_IMM,
      JMP_IMM,
      JNC_IMM,
      INVALID
   } opecode_t;

   localparam logic [3:0] NIB_MOV_A_B   = 4'b0001;
   localparam logic [3:0] NIB_MOV_B_A   = 4'b0100;
   localparam logic [3:0] NIB_MOV_A_IMM = 4'b0011;
   localparam logic [3:0] NIB_MOV_B_IMM = 4'b0111;
   localparam logic [3:0] NIB_IN_A      = 4'b0010;
   localparam logic [3:0] NIB_IN_B      = 4'b0110;
   localparam logic [3:0] NIB_OUT_B     = 4'b1001;
   localparam logic [3:0] NIB_OUT_IMM   = 4'b1011;
   localparam logic [3:0] NIB_ADD_A_IMM = 4'b0000;
   localparam logic [3:0] NIB_ADD_B_IMM = 4'b0101;
   localparam logic [3:0] NIB_JMP_IMM   = 4'b1111;
   localparam logic [3:0] NIB_JNC_IMM   = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FIN,
      ST_ERR
`ifdef PROG_LOADER_PAD_EN
      ,
      ST_PAD
`endif
   } loader_state_t;

endpackage

// File: rtl/prog_loader_inst_encoder.sv
// inst_encoder: combinational OPECODE + imm -> 8-bit instruction word.
// Register-only ops carry a zero immediate; unknown codes raise invalid.
module inst_encoder
   import lib_cpu::*;
(
   input  logic     [3:0] imm,
   input  opecode_t       opecode,
   output logic     [7:0] word,
   output logic           invalid
);

   // Opcode table lookup; lower nibble masked for non-immediate ops
   always_comb begin
      word    = '0;
      invalid = 1'b0;
      case (opecode)
         MOV_A_B:   word = {NIB_MOV_A_B,   4'b0000};
         MOV_B_A:   word = {NIB_MOV_B_A,   4'b0000};
         MOV_A_IMM: word = {NIB_MOV_A_IMM, imm};
         MOV_B_IMM: word = {NIB_MOV_B_IMM, imm};
         IN_A:      word = {NIB_IN_A,      4'b0000};
         IN_B:      word = {NIB_IN_B,      4'b0000};
         OUT_B:     word = {NIB_OUT_B,     4'b0000};
         OUT_IMM:   word = {NIB_OUT_IMM,   imm};
         ADD_A_IMM: word = {NIB_ADD_A_IMM, imm};
         ADD_B_IMM: word = {NIB_ADD_B_IMM, imm};
         JMP_IMM:   word = {NIB_JMP_IMM,   imm};
         JNC_IMM:   word = {NIB_JNC_IMM,   imm};
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: accepts (opcode, imm) pairs over valid/ready, encodes them
// and writes program memory sequentially from address 0 while holding the CPU.
// Optional build macro: PROG_LOADER_PAD_EN (fill unused words with JMP-to-self).
module prog_loader
   import lib_cpu::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  opecode_t          in_opecode,
   input  logic [3:0]        in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] PTR_TOP = '1;

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              pend_q, pend_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              error_q, error_d;
   logic [7:0]        enc_word;
   logic              enc_invalid;

   inst_encoder u_enc (
      .imm     (in_imm),
      .opecode (in_opecode),
      .word    (enc_word),
      .invalid (enc_invalid)
   );

   // State, pointer and registered memory write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         pend_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         error_q     <= error_d;
      end
   end

   // Next-state and handshake decode; pend marks the final write in flight,
   // so FIN (done) lands one cycle after that write with mem_we already low
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      pend_d      = pend_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      error_d     = error_q;
      in_ready    = 1'b0;
      cpu_hold    = 1'b1;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cpu_hold = 1'b0;
            if (start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               pend_d  = 1'b0;
               error_d = 1'b0;
            end
         end
         ST_LOAD: begin
            in_ready = !pend_q;
            if (pend_q) begin
               pend_d = 1'b0;
`ifdef PROG_LOADER_PAD_EN
               // pointer wrapped to 0 only when the top address was written
               state_d = (ptr_q != '0) ? ST_PAD : ST_FIN;
`else
               state_d = ST_FIN;
`endif
            end else if (in_valid) begin
               if (enc_invalid) begin
                  error_d = 1'b1;
                  state_d = ST_ERR;
               end else begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ptr_q;
                  mem_wdata_d = enc_word;
                  ptr_d       = ptr_q + ADDR_W'(1);
                  pend_d      = in_last || (ptr_q == PTR_TOP);
               end
            end
         end
`ifdef PROG_LOADER_PAD_EN
         ST_PAD: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = ST_FIN;
            end else begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_q;
               mem_wdata_d = {NIB_JMP_IMM, 4'(ptr_q)};
               ptr_d       = ptr_q + ADDR_W'(1);
               pend_d      = (ptr_q == PTR_TOP);
            end
         end
`endif
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               pend_d  = 1'b0;
               error_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader. Expected writes are
// pushed when a pair is accepted and popped by a write monitor.
// Honours PROG_LOADER_PAD_EN the same way as the design.
module tb_prog_loader;
   import lib_cpu::*;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_ready, in_last;
   opecode_t   in_opecode;
   logic [3:0] in_imm;
   logic       mem_we, cpu_hold, done, error;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;
   int unsigned wr_cyc = 0;
   int unsigned n_wr = 0;
   logic [3:0]  last_wr_addr = '0;
   wr_t         sb[$];

   prog_loader #(.ADDR_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opecode (in_opecode),
      .in_imm     (in_imm),
      .in_last    (in_last),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // independent reference encoding: {invalid, word}
   function automatic logic [8:0] model_enc(input opecode_t op, input logic [3:0] imm);
      case (op)
         MOV_A_B:   return {1'b0, 8'h10};
         MOV_B_A:   return {1'b0, 8'h40};
         MOV_A_IMM: return {1'b0, 4'h3, imm};
         MOV_B_IMM: return {1'b0, 4'h7, imm};
         IN_A:      return {1'b0, 8'h20};
         IN_B:      return {1'b0, 8'h60};
         OUT_B:     return {1'b0, 8'h90};
         OUT_IMM:   return {1'b0, 4'hB, imm};
         ADD_A_IMM: return {1'b0, 4'h0, imm};
         ADD_B_IMM: return {1'b0, 4'h5, imm};
         JMP_IMM:   return {1'b0, 4'hF, imm};
         JNC_IMM:   return {1'b0, 4'hE, imm};
         default:   return {1'b1, 8'h00};
      endcase
   endfunction

   // write monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we) begin
         chk("sb_has_entry", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
         end
         wr_cyc       = cyc;
         last_wr_addr = mem_addr;
         n_wr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("hold_after_start", cpu_hold, 1);
      chk("ready_after_start", in_ready, 1);
   endtask

   // offer one pair; expected write is pushed at the moment of acceptance
   task automatic send(input opecode_t op, input logic [3:0] imm, input logic last,
                       input logic [3:0] addr);
      bit          taken = 0;
      logic [8:0]  m;
      in_valid   = 1'b1;
      in_opecode = op;
      in_imm     = imm;
      in_last    = last;
      m = model_enc(op, imm);
      for (int i = 0; i < 20 && !taken; i++) begin
         #2;
         if (in_ready) begin
            taken = 1;
            if (!m[8]) sb.push_back({addr, m[7:0]});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!taken) chk("send_accept_timeout", 0, 1);
   endtask

   // wait for done and check its placement relative to the final write
   task automatic end_session(input int unsigned next_addr);
      int unsigned n = 0;
      logic [3:0]  exp_last;
      exp_last = 4'(next_addr - 1);
`ifdef PROG_LOADER_PAD_EN
      for (int unsigned a = next_addr; a < 16; a++) sb.push_back({4'(a), 4'hF, 4'(a)});
      exp_last = 4'hF;
`endif
      while (!done && n < 60) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done), 1);
      if (done) begin
         chk("done_after_last_wr", cyc - wr_cyc, 1);
         chk("last_wr_addr", last_wr_addr, exp_last);
         chk("sb_drained", sb.size(), 0);
         chk("hold_at_done", cpu_hold, 1);
         chk("we_at_done", mem_we, 0);
         chk("ready_at_done", in_ready, 0);
         tick();
         chk("done_one_cycle", done, 0);
         chk("hold_released", cpu_hold, 0);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_ready"}, in_ready, 0);
      chk({pfx, "_we"}, mem_we, 0);
      chk({pfx, "_hold"}, cpu_hold, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_error"}, error, 0);
      chk({pfx, "_addr"}, mem_addr, 0);
      chk({pfx, "_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      int unsigned w0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_opecode = MOV_A_B; in_imm = '0;
      tick(); tick();
      rst = 1'b0;
      chk_reset_vals("rst");

      // basic load with immediate masking on OUT_B
      do_start();
      send(MOV_A_IMM, 4'd3, 1'b0, 4'd0);
      send(ADD_A_IMM, 4'd1, 1'b0, 4'd1);
      send(OUT_B,     4'd7, 1'b1, 4'd2);
      chk("ready_after_last", in_ready, 0);
      end_session(3);

      // backpressure / gaps with random pairs
      w0 = n_wr;
      do_start();
      for (int i = 0; i < 8; i++) begin
         int unsigned gap = $urandom_range(0, 2);
         for (int g = 0; g < int'(gap); g++) tick();
         send(opecode_t'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), i == 7, 4'(i));
      end
      end_session(8);
      chk("bp_write_count", n_wr - w0, (8 + 0) +
`ifdef PROG_LOADER_PAD_EN
          8
`else
          0
`endif
      );

      // full depth: 16 JMP words, 17th offer refused
      do_start();
      for (int i = 0; i < 16; i++) send(JMP_IMM, 4'(i), 1'b0, 4'(i));
      chk("ready_after_top", in_ready, 0);
      in_valid = 1'b1; in_opecode = MOV_A_B;
      end_session(16);
      tick(); tick();
      chk("no_accept_in_idle", in_ready, 0);
      in_valid = 1'b0;

      // invalid opcode
      do_start();
      send(ADD_B_IMM, 4'd2, 1'b0, 4'd0);
      send(INVALID,   4'd9, 1'b0, 4'd1);
      chk("err_set", error, 1);
      chk("err_hold", cpu_hold, 1);
      chk("err_ready", in_ready, 0);
      chk("err_no_we", mem_we, 0);
      tick(); tick(); tick();
      chk("err_sticky", error, 1);
      do_start();
      chk("err_cleared", error, 0);
      send(MOV_B_IMM, 4'd5, 1'b1, 4'd0);
      end_session(1);

      // reset at pointer 5
      do_start();
      for (int i = 0; i < 5; i++) send(IN_B, 4'(i), 1'b0, 4'(i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_vals("midrst");
      in_valid = 1'b1; in_opecode = MOV_A_B;
      tick(); tick(); tick();
      in_valid = 1'b0;
      chk("midrst_sb_empty", sb.size(), 0);
      do_start();
      send(IN_A, 4'd9, 1'b1, 4'd0);
      end_session(1);

      // short session: padding when enabled, plain finish otherwise
      do_start();
      send(MOV_A_B, 4'd6, 1'b0, 4'd0);
      send(OUT_IMM, 4'd5, 1'b1, 4'd1);
      end_session(2);

      tick(); tick();
      chk("final_sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
